// File: rtl/uart_pkg.sv
// Shared constants and the stored-entry type for the UART 24-to-8 byte unpacker.
package uart_pkg;

   localparam int unsigned UART_WORD_W     = 32;
   localparam int unsigned UART_DATA_BYTES = 3;
   localparam int unsigned UART_BYTE_W     = 8;

   typedef struct packed {
      logic [UART_DATA_BYTES*UART_BYTE_W-1:0] data;
      logic [1:0]                             nbytes;
   } uart_entry_t;

endpackage

// File: rtl/uart_word_fifo2.sv
// Two-entry word FIFO with 1-bit wrapping pointers and a head view for fall-through reads.
module uart_word_fifo2
   import uart_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  uart_entry_t push_entry,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output uart_entry_t head
);

   uart_entry_t mem_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  count_q;
   logic        push_ok;
   logic        pop_ok;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_reg24to8.sv
// Buffers up to two packed 24-bit words and streams their valid bytes LSB-first.
module uart_reg24to8
   import uart_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wren,
   input  logic [UART_WORD_W-1:0] din,
   input  logic [1:0]             valid_bytes,
   output logic                   full,
   input  logic                   rden,
   output logic [UART_BYTE_W-1:0] dout,
   output logic                   empty,
   output logic                   overflow
);

   uart_entry_t push_entry;
   uart_entry_t head;
   logic        accept;
   logic        rd_act;
   logic        last_byte;
   logic        pop_word;
   logic [1:0]  byte_idx_q;
   logic        overflow_q;
   logic        unused_din;

   assign unused_din = ^din[UART_WORD_W-1:UART_DATA_BYTES*UART_BYTE_W];

   assign push_entry = '{data: din[UART_DATA_BYTES*UART_BYTE_W-1:0], nbytes: valid_bytes};
   assign accept     = wren && !full && (valid_bytes != 2'd0);
   assign rd_act     = rden && !empty;
   assign last_byte  = (byte_idx_q == head.nbytes - 2'd1);
   assign pop_word   = rd_act && last_byte;
   assign overflow   = overflow_q;

   uart_word_fifo2 u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (pop_word),
      .full       (full),
      .empty      (empty),
      .head       (head)
   );

   always_comb begin
      dout = '0;
      if (!empty) begin
         case (byte_idx_q)
            2'd0:    dout = head.data[7:0];
            2'd1:    dout = head.data[15:8];
            2'd2:    dout = head.data[23:16];
            default: dout = '0;
         endcase
      end
   end

   // Zero-byte writes are discarded silently, so they never count as a dropped write.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx_q <= 2'd0;
         overflow_q <= 1'b0;
      end else begin
         if (rd_act) begin
            byte_idx_q <= last_byte ? 2'd0 : byte_idx_q + 2'd1;
         end
         if (wren && full && (valid_bytes != 2'd0)) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule
